// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - widths, FSM states and control structs for the PE tile sequencer
package pe_seq_pkg;

  localparam int A_W          = 8;
  localparam int C_W          = 20;
  localparam int SHIFT_W      = 5;
  localparam int ID_W         = 3;
  localparam int MAX_ROWS     = 16;
  localparam int CNT_W        = $clog2(MAX_ROWS + 1);
  localparam int DRAIN_CYCLES = 16;
  localparam int TMR_W        = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic               dataflow;
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
    logic [ID_W-1:0]    id;
    logic               last;
  } pe_ctrl_t;

  typedef struct packed {
    logic [CNT_W-1:0]   rows;
    logic               dataflow;
    logic [SHIFT_W-1:0] shift;
    logic [ID_W-1:0]    id;
  } tile_cmd_t;

  function automatic logic [CNT_W-1:0] clamp_rows(input logic [CNT_W-1:0] rows);
    return (rows > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : rows;
  endfunction

endpackage

// File: rtl/pe_tile_sequencer.sv
// rtl/pe_tile_sequencer.sv - streams one tile of operand beats into the PE, drains, reports done
module pe_tile_sequencer
  import pe_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_rows,
  input  logic               cmd_dataflow,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [A_W-1:0]     op_a,
  input  logic [C_W-1:0]     op_b,
  input  logic [C_W-1:0]     op_d,
  output logic               pe_valid,
  output logic [A_W-1:0]     pe_a,
  output logic [C_W-1:0]     pe_b,
  output logic [C_W-1:0]     pe_d,
  output logic               pe_dataflow,
  output logic               pe_propagate,
  output logic [SHIFT_W-1:0] pe_shift,
  output logic [ID_W-1:0]    pe_id,
  output logic               pe_last,
  output logic               done_valid,
  output logic [ID_W-1:0]    done_id
);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  pe_ctrl_t         ctrl;
  tile_cmd_t        cmd_in;
  logic             cmd_fire, op_fire, drain_end;

  assign cmd_in    = '{rows: clamp_rows(cmd_rows), dataflow: cmd_dataflow,
                       shift: cmd_shift, id: cmd_id};
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign drain_end = (state == DRAIN) && (timer == TMR_W'(DRAIN_CYCLES - 1));

  // The done pulse cycle is already IDLE; holding cmd_ready low there keeps the
  // next accept strictly after the pulse.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = rst_n & ~done_valid;
        if (cmd_valid && rst_n && !done_valid)
          state_next = (cmd_in.rows == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        op_ready = rst_n;
        if (op_valid && rst_n && cnt == CNT_W'(1))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (timer == TMR_W'(DRAIN_CYCLES - 1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      timer      <= '0;
      ctrl       <= '0;
      pe_valid   <= 1'b0;
      pe_a       <= '0;
      pe_b       <= '0;
      pe_d       <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      state      <= state_next;
      pe_valid   <= 1'b0;
      ctrl.last  <= 1'b0;
      done_valid <= 1'b0;
      if (cmd_fire) begin
        ctrl.dataflow <= cmd_in.dataflow;
        ctrl.shift    <= cmd_in.shift;
        ctrl.id       <= cmd_in.id;
        if (cmd_in.rows != '0)
          ctrl.propagate <= ~ctrl.propagate;
        cnt   <= cmd_in.rows;
        timer <= '0;
      end
      if (op_fire) begin
        pe_valid  <= 1'b1;
        pe_a      <= op_a;
        pe_b      <= op_b;
        pe_d      <= op_d;
        ctrl.last <= (cnt == CNT_W'(1));
        cnt       <= cnt - CNT_W'(1);
      end
      if (state == DRAIN) begin
        if (drain_end) begin
          done_valid <= 1'b1;
          done_id    <= ctrl.id;
          timer      <= '0;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end
    end
  end

  assign pe_dataflow  = ctrl.dataflow;
  assign pe_propagate = ctrl.propagate;
  assign pe_shift     = ctrl.shift;
  assign pe_id        = ctrl.id;
  assign pe_last      = ctrl.last;

endmodule
